// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, memory-wait freeze and registered EX operand forward selects
// for the 5-stage core. Define HAZ_PERF_CNT_EN to add the saturating stall_cnt output.
module hazard_ctrl #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_wen,
    input  logic                  id_is_load,
    input  logic                  ex_flush,
    input  logic                  mem_busy,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  freeze_all,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_MEM_WAIT
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic                  is_load;
        logic [ADDR_WIDTH-1:0] rd;
    } ex_slot_t;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [ADDR_WIDTH-1:0] rd;
    } mem_slot_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    state_t    state_q, state_d;
    ex_slot_t  ex_q, ex_d;
    mem_slot_t mem_q, mem_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic       load_use;
    logic       lu_hazard;
    logic       bubble_in;

    function automatic logic reg_match(
        input logic                  valid,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] rd,
        input logic [ADDR_WIDTH-1:0] rs,
        input logic                  used
    );
        return used & valid & wen & (rd == rs) & (rs != '0);
    endfunction

    // EX holds the youngest producer, so it wins over MEM; a load in EX never forwards from EX
    function automatic logic [1:0] fwd_select(
        input ex_slot_t              ex,
        input mem_slot_t             mem,
        input logic [ADDR_WIDTH-1:0] rs,
        input logic                  used
    );
        if (reg_match(ex.valid, ex.wen, ex.rd, rs, used) && !ex.is_load) begin
            return FWD_EXMEM;
        end
        if (reg_match(mem.valid, mem.wen, mem.rd, rs, used)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        state_d     = state_q;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        freeze_all  = 1'b0;
        load_use    = id_valid & ex_q.is_load &
                      (reg_match(ex_q.valid, ex_q.wen, ex_q.rd, id_rs1, id_rs1_used) |
                       reg_match(ex_q.valid, ex_q.wen, ex_q.rd, id_rs2, id_rs2_used));
        // a flush kills both the load in EX and the dependent in ID, so there is nothing to stall
        lu_hazard   = load_use & ~ex_flush;

        unique case (state_q)
            ST_RUN: begin
                stall_if_id = lu_hazard;
                bubble_ex   = lu_hazard;
                if (mem_busy) begin
                    state_d = ST_MEM_WAIT;
                end else if (lu_hazard) begin
                    state_d = ST_LU_STALL;
                end
            end
            ST_LU_STALL: begin
                state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                freeze_all  = 1'b1;
                stall_if_id = 1'b1;
                if (!mem_busy) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;
        bubble_in = bubble_ex | ex_flush | ~id_valid;

        if (!freeze_all) begin
            if (ex_flush) begin
                mem_d = '0;
            end else begin
                mem_d = '{valid: ex_q.valid, wen: ex_q.wen, rd: ex_q.rd};
            end

            if (bubble_in) begin
                ex_d    = '0;
                fwd_a_d = FWD_RF;
                fwd_b_d = FWD_RF;
            end else begin
                ex_d    = '{valid: 1'b1, wen: id_wen, is_load: id_is_load, rd: id_rd};
                fwd_a_d = fwd_select(ex_q, mem_q, id_rs1, id_rs1_used);
                fwd_b_d = fwd_select(ex_q, mem_q, id_rs2, id_rs2_used);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, reset-during-wait sequence and a randomized
// run checked against a youngest-producer pipeline model.
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_rs1_used, id_rs2_used;
    logic          id_wen, id_is_load;
    logic          ex_flush, mem_busy;
    logic          stall_if_id, bubble_ex, freeze_all;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_wen      (id_wen),
        .id_is_load  (id_is_load),
        .ex_flush    (ex_flush),
        .mem_busy    (mem_busy),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .freeze_all  (freeze_all),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          v;
        logic [AW-1:0] rs1, rs2;
        logic          u1, u2;
        logic [AW-1:0] rd;
        logic          wen, ld, fl, busy;
        logic          stall, bub, frz;
        logic [1:0]    fa, fb;
    } vec_t;

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                                input logic u2, input int rd, input logic wen, input logic ld,
                                input logic fl, input logic busy, input logic stall,
                                input logic bub, input logic frz, input int fa, input int fb);
        vec_t r;
        r.v = v; r.rs1 = AW'(rs1); r.rs2 = AW'(rs2); r.u1 = u1; r.u2 = u2; r.rd = AW'(rd);
        r.wen = wen; r.ld = ld; r.fl = fl; r.busy = busy;
        r.stall = stall; r.bub = bub; r.frz = frz; r.fa = 2'(fa); r.fb = 2'(fb);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2, input logic [AW-1:0] rd,
                         input logic wen, input logic ld, input logic fl, input logic busy);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        id_rd = rd; id_wen = wen; id_is_load = ld; ex_flush = fl; mem_busy = busy;
    endtask

    task automatic do_reset();
        drive(0, '0, '0, 0, 0, '0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- reference model: pipeline of in-flight producers ----------------
    typedef struct {
        logic          v, w, ld;
        logic [AW-1:0] rd;
    } ins_t;

    ins_t       m_ex, m_mem;
    logic       m_wait, m_lu;
    logic [1:0] m_fa, m_fb;
    int         m_cnt;

    function automatic logic writes(input ins_t p, input logic [AW-1:0] rs, input logic used);
        return used && rs != 0 && p.v && p.w && p.rd == rs;
    endfunction

    // youngest in-flight writer of rs decides the source; a load still in EX has no value yet
    function automatic logic [1:0] source_of(input logic [AW-1:0] rs, input logic used);
        if (writes(m_ex, rs, used)) return m_ex.ld ? 2'd0 : 2'd1;
        if (writes(m_mem, rs, used)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic hazard();
        return !m_wait && !m_lu && id_valid && !ex_flush && m_ex.ld &&
               (writes(m_ex, id_rs1, id_rs1_used) || writes(m_ex, id_rs2, id_rs2_used));
    endfunction

    task automatic model_reset();
        m_ex = '{default: '0}; m_mem = '{default: '0};
        m_wait = 0; m_lu = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
    endtask

    task automatic model_check();
        logic hz;
        hz = hazard();
        chk("rnd_stall",  {15'd0, stall_if_id}, {15'd0, m_wait | hz});
        chk("rnd_bubble", {15'd0, bubble_ex},   {15'd0, hz});
        chk("rnd_freeze", {15'd0, freeze_all},  {15'd0, m_wait});
        chk("rnd_fwd_a",  {14'd0, fwd_a_sel},   {14'd0, m_fa});
        chk("rnd_fwd_b",  {14'd0, fwd_b_sel},   {14'd0, m_fb});
`ifdef HAZ_PERF_CNT_EN
        chk("rnd_stall_cnt", stall_cnt, 16'(m_cnt));
`endif
    endtask

    task automatic model_advance(input logic hz);
        ins_t nu;
        logic killed;
        if (m_wait || hz) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (m_wait) begin
            if (!mem_busy) m_wait = 0;
        end else begin
            killed = hz || ex_flush || !id_valid;
            nu = '{v: 1'b1, w: id_wen, ld: id_is_load, rd: id_rd};
            m_fa = killed ? 2'd0 : source_of(id_rs1, id_rs1_used);
            m_fb = killed ? 2'd0 : source_of(id_rs2, id_rs2_used);
            m_mem = ex_flush ? '{default: '0} : m_ex;
            m_ex  = killed ? '{default: '0} : nu;
            if (m_lu) m_lu = 0;
            else if (mem_busy) m_wait = 1;
            else if (hz) m_lu = 1;
        end
    endtask

    vec_t tbl[21];

    initial begin
        tbl[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0); // add x5
        tbl[1]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0); // sub x6,x5,x5
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1); // sub in EX: 01/01
        tbl[3]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0); // add x5
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // nop
        tbl[5]  = mk(1, 5, 0, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0); // or x7,x5,x0
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0); // or in EX: 10/00
        tbl[7]  = mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0); // lw x3
        tbl[8]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0,  1, 1, 0, 0, 0); // add x4,x3,x1: stall
        tbl[9]  = mk(1, 3, 1, 1, 1, 4, 1, 0, 0, 0,  0, 0, 0, 0, 0); // held add, no stall
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0); // add in EX: 10/00
        tbl[11] = mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0); // lw x3
        tbl[12] = mk(1, 3, 3, 1, 1, 4, 1, 0, 1, 0,  0, 0, 0, 0, 0); // flush with dependent
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // EX bubble
        tbl[14] = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0); // add x5
        tbl[15] = mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1,  0, 0, 0, 0, 0); // sub, mem_busy rises
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 1); // frozen
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 1, 1, 1); // frozen
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1); // busy fell, still frozen
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1); // RUN, fwd held
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // bubble entered EX

        do_reset();
        @(posedge clk); #1;
        chk("reset_stall",  {15'd0, stall_if_id}, 16'd0);
        chk("reset_freeze", {15'd0, freeze_all},  16'd0);
        chk("reset_fwd_a",  {14'd0, fwd_a_sel},   16'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("reset_stall_cnt", stall_cnt, 16'd0);
`endif

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                  tbl[i].wen, tbl[i].ld, tbl[i].fl, tbl[i].busy);
            #4;
            chk($sformatf("vec%0d_stall", i),  {15'd0, stall_if_id}, {15'd0, tbl[i].stall});
            chk($sformatf("vec%0d_bubble", i), {15'd0, bubble_ex},   {15'd0, tbl[i].bub});
            chk($sformatf("vec%0d_freeze", i), {15'd0, freeze_all},  {15'd0, tbl[i].frz});
            chk($sformatf("vec%0d_fwd_a", i),  {14'd0, fwd_a_sel},   {14'd0, tbl[i].fa});
            chk($sformatf("vec%0d_fwd_b", i),  {14'd0, fwd_b_sel},   {14'd0, tbl[i].fb});
`ifdef HAZ_PERF_CNT_EN
            if (i == 19) chk("vec_stall_cnt", stall_cnt, 16'd4);
`endif
            @(posedge clk); #1;
        end

        // reset asserted in the middle of a memory wait
        drive(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("wait_freeze", {15'd0, freeze_all}, 16'd1);
        chk("wait_fwd_a",  {14'd0, fwd_a_sel},  16'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_freeze", {15'd0, freeze_all},  16'd0);
        chk("async_rst_stall",  {15'd0, stall_if_id}, 16'd0);
        chk("async_rst_bubble", {15'd0, bubble_ex},   16'd0);
        chk("async_rst_fwd_a",  {14'd0, fwd_a_sel},   16'd0);
        chk("async_rst_fwd_b",  {14'd0, fwd_b_sel},   16'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("async_rst_stall_cnt", stall_cnt, 16'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 6, 5, 1, 1, 7, 1, 0, 0, 0);
        #4;
        chk("post_rst_freeze", {15'd0, freeze_all}, 16'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("post_rst_fwd_a", {14'd0, fwd_a_sel}, 16'd0);
        chk("post_rst_fwd_b", {14'd0, fwd_b_sel}, 16'd0);
        @(posedge clk); #1;

        // randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic hz;
            drive($urandom_range(0, 9) < 8, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), AW'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2);
            #4;
            model_check();
            hz = hazard();
            @(posedge clk); #1;
            model_advance(hz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
